alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Parametrised iterative multiply/divide unit beside the single-cycle ALU/barrel shifter.
//  Replaces the truncated combinational MUL with a WIDTH-bit radix-2 engine: 1 bit/cycle.
//  Adds high-word multiply, divide and remainder, with valid/ready handshakes.
//  The CPU stalls while a result is outstanding.
// PARAMETERS
//  WIDTH     32   operand/result width; >= 4
//  CNT_W     $clog2(WIDTH+1)   iteration counter width; derived, do not override
// PORTS
//  clk        in   1      core clock, rising edge
//  reset_b    in   1      asynchronous active-low reset
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      unit accepts operands (IDLE only)
//  op         in   3      [1:0] 00 MUL(low) 01 MULH(high) 10 DIV 11 REM; [2] signed (MDU_SIGNED_EN)
//  din_a      in   WIDTH  multiplicand / dividend
//  din_b      in   WIDTH  multiplier / divisor
//  abort      in   1      flush in-flight op (pipeline redirect)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result
//  dout       out  WIDTH  result
//  vout       out  1      overflow flag
//  zout       out  1      dout == 0
//  dzout      out  1      divide by zero
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; out_valid=0; dout=0; vout=zout=dzout=0; counter=0.
//  - FSM: IDLE -> BUSY -> (FIXUP) -> DONE -> IDLE.
//  - IDLE: in_ready=1. in_valid&in_ready at edge N latches op, din_a, din_b; counter=WIDTH; go BUSY.
//  - BUSY: one iteration/edge; counter decrements; leaves when the counter would reach 0.
//    MUL/MULH: shift-add into 2*WIDTH product register.
//    DIV/REM: restoring division into quotient and partial-remainder registers, WIDTH+1 bits.
//  - Latency: unsigned out_valid=1 after edge N+WIDTH; signed adds FIXUP, so N+WIDTH+1.
//  - Divide by zero (DIV/REM, din_b==0): skip BUSY; DONE after edge N+1.
//    DIV -> all ones; REM -> din_a; dzout=1.
//  - DONE: out_valid=1; dout and flags held stable while out_ready=0.
//    out_valid&out_ready -> IDLE next edge; out_valid=0. No new op accepted in the DONE cycle.
//  - in_ready=0 in BUSY, FIXUP and DONE. in_valid is ignored there, and no operand update.
//  - abort: any state -> IDLE on next edge; out_valid=0; flags cleared; abort outranks out_ready.
//  - abort with in_valid in IDLE: abort wins; op not accepted.
//  - Flags, registered with dout:
//    vout MUL = high word nonzero; MULH = 0; DIV/REM unsigned = 0.
//    zout = (dout==0). dzout=1 only for a divide-by-zero op.
//  - Reset mid-operation: immediate return to reset values; the partial result is discarded.
// CONFIGURATION
//  MDU_SIGNED_EN defined:
//  - op[2]=1 selects two's-complement operation.
//  - Operands are converted to magnitudes at accept; FIXUP negates the result per sign rules.
//    MULH returns the signed high word.
//    DIV truncates toward zero; REM takes the sign of the dividend.
//    Signed MUL vout = high word not a sign extension of the low word.
//  - MIN / -1: DIV -> MIN, REM -> 0, vout=1.
//  - Divide by zero is unchanged: DIV -> all ones, REM -> din_a.
//  MDU_SIGNED_EN undefined:
//  - op[2] is ignored; all ops unsigned; no FIXUP state; latency is always WIDTH (or 1 for /0).
// TESTING (WIDTH=32)
//  1. MUL 0x00010000*0x00010000 accepted edge N -> out_valid after N+32; dout=0, zout=1, vout=1.
//  2. MULH 0xFFFFFFFF*0xFFFFFFFF -> dout=0xFFFFFFFE; then MUL -> dout=0x00000001, vout=1.
//  3. DIV 100/7 -> 14, REM 100/7 -> 2; DIV 5/0 -> 0xFFFFFFFF, dzout=1, out_valid after N+1.
//  4. out_ready=0 for 5 cycles in DONE -> dout/flags stable, in_ready=0; out_ready=1 -> IDLE next edge.
//  5. abort at N+10 -> IDLE at N+11, out_valid never 1; reset_b low mid-BUSY -> all reset values at once.
//  6. MDU_SIGNED_EN: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; 0x80000000/-1 -> 0x80000000, vout=1.
//     Latency N+33.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Iterative radix-2 multiply/divide unit (MUL, MULH, DIV, REM) with valid/ready handshakes.
// Optional feature macro: MDU_SIGNED_EN enables two's-complement ops via op[2] and a FIXUP state.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             vout,
  output logic             zout,
  output logic             dzout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

`ifdef MDU_SIGNED_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_FIXUP = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd3} state_t;
`endif

  state_t               r_state;
  state_t               w_stateNext;
  logic [CNT_W-1:0]     r_cnt;
  logic [1:0]           r_op;
  logic                 r_sgn;
  logic                 r_negA;
  logic                 r_negB;
  logic                 r_ovf;
  logic                 r_dz;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_prod;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_dout;
  logic                 r_vout;
  logic                 r_zout;
  logic                 r_dzout;

  logic                 w_sgnIn;
  logic                 w_isDiv;
  logic                 w_dz;
  logic                 w_ovfIn;
  logic                 w_lastIter;
  logic [WIDTH-1:0]     w_magA;
  logic [WIDTH-1:0]     w_magB;
  logic [WIDTH:0]       w_addHi;
  logic [2*WIDTH-1:0]   w_prodNext;
  logic [WIDTH:0]       w_remShift;
  logic [WIDTH:0]       w_remDiff;
  logic [WIDTH-1:0]     w_remNext;
  logic [WIDTH-1:0]     w_quoNext;
  logic [2*WIDTH-1:0]   w_pSrc;
  logic [2*WIDTH-1:0]   w_p;
  logic [WIDTH-1:0]     w_qSrc;
  logic [WIDTH-1:0]     w_rSrc;
  logic                 w_neg;
  logic [WIDTH-1:0]     w_res;
  logic                 w_resV;

`ifdef MDU_SIGNED_EN
  assign w_sgnIn = op[2];
`else
  logic w_unusedSign;
  assign w_sgnIn      = 1'b0;
  assign w_unusedSign = op[2];
`endif

  // Operands are reduced to magnitudes at accept; the sign is restored in FIXUP.
  assign w_isDiv    = op[1];
  assign w_dz       = w_isDiv && (din_b == '0);
  assign w_magA     = (w_sgnIn && din_a[WIDTH-1]) ? -din_a : din_a;
  assign w_magB     = (w_sgnIn && din_b[WIDTH-1]) ? -din_b : din_b;
  assign w_ovfIn    = w_sgnIn && w_isDiv && (din_a == {1'b1, {(WIDTH-1){1'b0}}}) && (din_b == '1);
  assign w_lastIter = (r_cnt == CNT_W'(1));

  assign w_addHi    = r_prod[0] ? ({1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd})
                                : {1'b0, r_prod[2*WIDTH-1:WIDTH]};
  assign w_prodNext = {w_addHi, r_prod[WIDTH-1:1]};

  // Restoring step: a borrow out of the WIDTH+1 bit difference means the divisor did not fit.
  assign w_remShift = {r_rem, r_quo[WIDTH-1]};
  assign w_remDiff  = w_remShift - {1'b0, r_opnd};
  assign w_remNext  = w_remDiff[WIDTH] ? w_remShift[WIDTH-1:0] : w_remDiff[WIDTH-1:0];
  assign w_quoNext  = {r_quo[WIDTH-2:0], ~w_remDiff[WIDTH]};

  always_comb begin
    w_pSrc = r_prod;
    w_qSrc = r_quo;
    w_rSrc = r_rem;
    w_neg  = 1'b0;
    if (r_state == S_BUSY) begin
      w_pSrc = w_prodNext;
      w_qSrc = w_quoNext;
      w_rSrc = w_remNext;
    end else if (r_sgn) begin
      w_neg = (r_op == 2'b11) ? r_negA : (r_negA ^ r_negB);
    end
    w_p    = w_neg ? -w_pSrc : w_pSrc;
    w_res  = '0;
    w_resV = 1'b0;
    case (r_op)
      OP_MUL: begin
        w_res  = w_p[WIDTH-1:0];
        w_resV = r_sgn ? (w_p[2*WIDTH-1:WIDTH] != {WIDTH{w_p[WIDTH-1]}})
                       : (|w_p[2*WIDTH-1:WIDTH]);
      end
      OP_MULH: w_res = w_p[2*WIDTH-1:WIDTH];
      OP_DIV: begin
        w_res  = w_neg ? -w_qSrc : w_qSrc;
        w_resV = r_ovf;
      end
      default: begin
        w_res  = w_neg ? -w_rSrc : w_rSrc;
        w_resV = r_ovf;
      end
    endcase
    if (r_dz) begin
      w_res  = (r_op == OP_DIV) ? '1 : r_quo;
      w_resV = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) r_state <= S_IDLE;
    else          r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_stateNext = S_BUSY;
      end
      S_BUSY: begin
        if (r_dz) begin
          w_stateNext = S_DONE;
        end else if (w_lastIter) begin
`ifdef MDU_SIGNED_EN
          w_stateNext = r_sgn ? S_FIXUP : S_DONE;
`else
          w_stateNext = S_DONE;
`endif
        end
      end
`ifdef MDU_SIGNED_EN
      S_FIXUP: w_stateNext = S_DONE;
`endif
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
    if (abort) w_stateNext = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_sgn   <= 1'b0;
      r_negA  <= 1'b0;
      r_negB  <= 1'b0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
      r_opnd  <= '0;
      r_prod  <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dout  <= '0;
      r_vout  <= 1'b0;
      r_zout  <= 1'b0;
      r_dzout <= 1'b0;
    end else if (abort) begin
      r_cnt   <= '0;
      r_dz    <= 1'b0;
      r_dout  <= '0;
      r_vout  <= 1'b0;
      r_zout  <= 1'b0;
      r_dzout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op   <= op[1:0];
            r_sgn  <= w_sgnIn;
            r_negA <= w_sgnIn && din_a[WIDTH-1];
            r_negB <= w_sgnIn && din_b[WIDTH-1];
            r_ovf  <= w_ovfIn;
            r_dz   <= w_dz;
            r_cnt  <= w_dz ? '0 : CNT_W'(WIDTH);
            if (w_isDiv) begin
              r_opnd <= w_magB;
              r_quo  <= w_dz ? din_a : w_magA;
              r_rem  <= '0;
            end else begin
              r_opnd <= w_magA;
              r_prod <= {{WIDTH{1'b0}}, w_magB};
            end
          end
        end
        S_BUSY: begin
          if (r_dz) begin
            r_dout  <= w_res;
            r_vout  <= w_resV;
            r_zout  <= (w_res == '0);
            r_dzout <= 1'b1;
          end else begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_prod <= w_prodNext;
            r_quo  <= w_quoNext;
            r_rem  <= w_remNext;
            if (w_lastIter && !r_sgn) begin
              r_dout  <= w_res;
              r_vout  <= w_resV;
              r_zout  <= (w_res == '0);
              r_dzout <= 1'b0;
            end
          end
        end
`ifdef MDU_SIGNED_EN
        S_FIXUP: begin
          r_dout  <= w_res;
          r_vout  <= w_resV;
          r_zout  <= (w_res == '0);
          r_dzout <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign dout  = r_dout;
  assign vout  = r_vout;
  assign zout  = r_zout;
  assign dzout = r_dzout;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq at WIDTH=32; signed vectors run when MDU_SIGNED_EN is defined.
module tb_alu_muldiv_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          in_valid = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [W-1:0]  din_a = '0;
  logic [W-1:0]  din_b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  dout;
  logic          vout;
  logic          zout;
  logic          dzout;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [31:0] dout;
    logic        v;
    logic        z;
    logic        dz;
    int          lat;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  exp_t expQ[$];

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .din_a(din_a), .din_b(din_b), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .vout(vout), .zout(zout), .dzout(dzout)
  );

  always #5 clk = ~clk;

  // Reference results computed with wide native arithmetic.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic        sg;
    logic [63:0] p;
    longint      sa, sb, q, r;
`ifdef MDU_SIGNED_EN
    sg = o[2];
`else
    sg = 1'b0;
`endif
    e.v = 1'b0; e.dz = 1'b0; e.lat = sg ? 33 : 32; e.dout = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o[1]) begin
      p = sg ? 64'(sa * sb) : ({32'b0, a} * {32'b0, b});
      if (!o[0]) begin
        e.dout = p[31:0];
        e.v = sg ? (p[63:32] != {32{p[31]}}) : (p[63:32] != 32'h0);
      end else begin
        e.dout = p[63:32];
      end
    end else if (b == 32'h0) begin
      e.dout = o[0] ? a : 32'hFFFF_FFFF;
      e.dz = 1'b1; e.lat = 1;
    end else if (sg) begin
      q = sa / sb; r = sa % sb;
      e.dout = o[0] ? r[31:0] : q[31:0];
      e.v = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end else begin
      e.dout = o[0] ? (a % b) : (a / b);
    end
    e.z = (e.dout == 32'h0);
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; din_a = a; din_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    #12;
    checks++;
    if ({in_ready, out_valid, dout, vout, zout, dzout} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
      fails++;
      $display("[TB] FAIL reset: got rdy=%b val=%b dout=%h flags=%b%b%b required 1 0 0 000",
               in_ready, out_valid, dout, vout, zout, dzout);
    end
    @(posedge clk); #1;
    reset_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    vec_t v [7];
    exp_t e;
    int   lat;
    v = '{'{3'b000, 32'h0001_0000, 32'h0001_0000}, '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
          '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, '{3'b000, 32'd3, 32'd5},
          '{3'b001, 32'h1234_5678, 32'h9ABC_DEF0}, '{3'b000, 32'h0, 32'hDEAD_BEEF},
          '{3'b100, 32'hFFFF_FFFD, 32'd5}};
    for (int i = 0; i < 7; i++) begin
      expQ.push_back(model(v[i].op, v[i].a, v[i].b));
      issue(v[i].op, v[i].a, v[i].b);
      wait_done(lat);
      e = expQ.pop_front();
      checks++;
      if (lat !== e.lat) begin fails++; $display("[TB] FAIL mul[%0d] latency: got %0d required %0d", i, lat, e.lat); end
      checks++;
      if (dout !== e.dout) begin fails++; $display("[TB] FAIL mul[%0d] dout: got %h required %h", i, dout, e.dout); end
      checks++;
      if ({vout, zout, dzout} !== {e.v, e.z, e.dz}) begin
        fails++; $display("[TB] FAIL mul[%0d] vzd flags: got %b%b%b required %b%b%b", i, vout, zout, dzout, e.v, e.z, e.dz);
      end
      release_result();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++; $display("[TB] FAIL mul[%0d] release: got val=%b rdy=%b required 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_div();
    vec_t v [9];
    exp_t e;
    int   lat;
    v = '{'{3'b010, 32'd100, 32'd7}, '{3'b011, 32'd100, 32'd7}, '{3'b010, 32'd5, 32'd0},
          '{3'b011, 32'd5, 32'd0}, '{3'b010, 32'd7, 32'd100}, '{3'b011, 32'hFFFF_FFFF, 32'd1},
          '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, '{3'b110, 32'd100, 32'd7},
          '{3'b111, 32'hFFFF_FFF9, 32'd2}};
    for (int i = 0; i < 9; i++) begin
      expQ.push_back(model(v[i].op, v[i].a, v[i].b));
      issue(v[i].op, v[i].a, v[i].b);
      wait_done(lat);
      e = expQ.pop_front();
      checks++;
      if (lat !== e.lat) begin fails++; $display("[TB] FAIL div[%0d] latency: got %0d required %0d", i, lat, e.lat); end
      checks++;
      if (dout !== e.dout) begin fails++; $display("[TB] FAIL div[%0d] dout: got %h required %h", i, dout, e.dout); end
      checks++;
      if ({vout, zout, dzout} !== {e.v, e.z, e.dz}) begin
        fails++; $display("[TB] FAIL div[%0d] vzd flags: got %b%b%b required %b%b%b", i, vout, zout, dzout, e.v, e.z, e.dz);
      end
      release_result();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++; $display("[TB] FAIL div[%0d] release: got val=%b rdy=%b required 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    int   lat;
    expQ.push_back(model(3'b000, 32'h1234_5678, 32'h10));
    issue(3'b000, 32'h1234_5678, 32'h10);
    wait_done(lat);
    e = expQ.pop_front();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; op = 3'b010; din_a = 32'd9; din_b = 32'd0;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
        fails++; $display("[TB] FAIL hold[%0d] handshake: got val=%b rdy=%b required 1 0", k, out_valid, in_ready);
      end
      checks++;
      if ({dout, vout, zout, dzout} !== {e.dout, e.v, e.z, e.dz}) begin
        fails++; $display("[TB] FAIL hold[%0d] result: got %h/%b%b%b required %h/%b%b%b",
                          k, dout, vout, zout, dzout, e.dout, e.v, e.z, e.dz);
      end
    end
    in_valid = 1'b0;
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL hold release: got val=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_abort();
    int   lat;
    logic seenValid;
    issue(3'b000, 32'hCAFE_F00D, 32'h1234_5678);
    repeat (10) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL abort busy: got val=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    seenValid = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid === 1'b1) seenValid = 1'b1; end
    checks++;
    if (seenValid !== 1'b0) begin fails++; $display("[TB] FAIL abort quiet: got out_valid seen=%b required 0", seenValid); end

    issue(3'b010, 32'd5, 32'd0);
    wait_done(lat);
    checks++;
    if (dzout !== 1'b1) begin fails++; $display("[TB] FAIL abort pre-done dzout: got %b required 1", dzout); end
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, vout, zout, dzout} !== 5'b01000) begin
      fails++; $display("[TB] FAIL abort done: got val=%b rdy=%b flags=%b%b%b required 0 1 000",
                        out_valid, in_ready, vout, zout, dzout);
    end

    abort = 1'b1; in_valid = 1'b1; op = 3'b010; din_a = 32'd5; din_b = 32'd0;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL abort vs in_valid: got in_ready=%b required 1", in_ready); end
    seenValid = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (out_valid === 1'b1) seenValid = 1'b1; end
    checks++;
    if (seenValid !== 1'b0) begin fails++; $display("[TB] FAIL abort vs in_valid quiet: got seen=%b required 0", seenValid); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    e = model(3'b000, 32'd3, 32'd5);
    issue(3'b000, 32'd3, 32'd5);
    wait_done(lat);
    release_result();
    checks++;
    if (dout !== e.dout) begin fails++; $display("[TB] FAIL pre-reset dout: got %h required %h", dout, e.dout); end
    issue(3'b010, 32'd100, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    #2 reset_b = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, dout, vout, zout, dzout} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
      fails++; $display("[TB] FAIL mid reset: got rdy=%b val=%b dout=%h flags=%b%b%b required 1 0 0 000",
                        in_ready, out_valid, dout, vout, zout, dzout);
    end
    @(posedge clk); #1;
    reset_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          lat;
    logic [2:0]  o;
    logic [31:0] a, b;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      expQ.push_back(model(o, a, b));
      issue(o, a, b);
      wait_done(lat);
      e = expQ.pop_front();
      checks++;
      if (lat !== e.lat) begin fails++; $display("[TB] FAIL b2b[%0d] latency: got %0d required %0d", i, lat, e.lat); end
      checks++;
      if ({dout, vout, zout, dzout} !== {e.dout, e.v, e.z, e.dz}) begin
        fails++; $display("[TB] FAIL b2b[%0d] op=%b a=%h b=%h: got %h/%b%b%b required %h/%b%b%b",
                          i, o, a, b, dout, vout, zout, dzout, e.dout, e.v, e.z, e.dz);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b[%0d] in_ready: got %b required 1", i, in_ready); end
    end
    out_ready = 1'b0;
  endtask

`ifdef MDU_SIGNED_EN
  task automatic test_signed();
    vec_t v [9];
    exp_t e;
    int   lat;
    v = '{'{3'b110, 32'hFFFF_FFF9, 32'd2}, '{3'b111, 32'hFFFF_FFF9, 32'd2},
          '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF}, '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF},
          '{3'b100, 32'hFFFF_FFFD, 32'd5}, '{3'b101, 32'hFFFF_FFFD, 32'd5},
          '{3'b100, 32'h4000_0000, 32'd4}, '{3'b110, 32'd7, 32'hFFFF_FFFE},
          '{3'b111, 32'hFFFF_FFFB, 32'd0}};
    for (int i = 0; i < 9; i++) begin
      expQ.push_back(model(v[i].op, v[i].a, v[i].b));
      issue(v[i].op, v[i].a, v[i].b);
      wait_done(lat);
      e = expQ.pop_front();
      checks++;
      if (lat !== e.lat) begin fails++; $display("[TB] FAIL sgn[%0d] latency: got %0d required %0d", i, lat, e.lat); end
      checks++;
      if ({dout, vout, zout, dzout} !== {e.dout, e.v, e.z, e.dz}) begin
        fails++; $display("[TB] FAIL sgn[%0d] result: got %h/%b%b%b required %h/%b%b%b",
                          i, dout, vout, zout, dzout, e.dout, e.v, e.z, e.dz);
      end
      release_result();
    end
  endtask
`endif

  initial begin
    $display("[TB] starting alu_muldiv_seq bench");
    test_reset();
    test_mul();
    test_div();
    test_hold();
    test_abort();
    test_reset_mid();
    test_back_to_back();
`ifdef MDU_SIGNED_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
